// File: rtl/pipeline_elastic_if.sv
// Upstream/downstream valid/ready bundle for the elastic register pipeline.
// The master modport is the environment side; the slave modport is the pipeline side.
interface pipeline_elastic_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/pipeline_elastic.sv
// Parametrised valid/ready register pipeline with bubble collapse, synchronous flush
// and occupancy status. NUM_STAGES=0 degenerates to a combinational pass-through.
module pipeline_elastic #(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 2,
  localparam int CNT_W     = (NUM_STAGES > 0) ? $clog2(NUM_STAGES + 1) : 1
) (
  input  logic              clk_i,
  input  logic              arst_n,
  input  logic              flush_i,
  pipeline_elastic_if.slave bus,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  if (NUM_STAGES == 0) begin : g_wire
    assign bus.data_out       = bus.data_in;
    assign bus.data_out_valid = bus.data_in_valid & !flush_i;
    assign bus.data_in_ready  = bus.data_out_ready & !flush_i;
    assign count_o            = '0;
    assign empty_o            = 1'b1;
    assign full_o             = 1'b1;
  end else begin : g_pipe
    logic [NUM_STAGES-1:0] vld_p;
    logic [WIDTH-1:0]      dat_p [NUM_STAGES];
    logic [NUM_STAGES-1:0] rdy;
    logic [NUM_STAGES-1:0] in_v;
    logic [WIDTH-1:0]      in_d  [NUM_STAGES];

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_STAGES-1:0] v);
      logic [CNT_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < NUM_STAGES; i++) acc = acc + CNT_W'(v[i]);
      return acc;
    endfunction

    // A stage is ready when it is empty or every stage downstream of it can move.
    always_comb begin
      logic acc;
      acc = bus.data_out_ready;
      rdy = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        acc    = acc | !vld_p[i];
        rdy[i] = acc;
      end
    end

    always_comb begin
      in_v    = '0;
      in_v[0] = bus.data_in_valid;
      in_d[0] = bus.data_in;
      for (int i = 1; i < NUM_STAGES; i++) begin
        in_v[i] = vld_p[i-1];
        in_d[i] = dat_p[i-1];
      end
    end

    // stage registers: payload only loads behind a valid beat
    always_ff @(posedge clk_i or negedge arst_n) begin
      if (!arst_n) begin
        vld_p <= '0;
        for (int i = 0; i < NUM_STAGES; i++) dat_p[i] <= '0;
      end else if (flush_i) begin
        vld_p <= '0;
      end else begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (rdy[i]) begin
            vld_p[i] <= in_v[i];
            if (in_v[i]) dat_p[i] <= in_d[i];
          end
        end
      end
    end

    assign bus.data_in_ready  = rdy[0] & !flush_i;
    assign bus.data_out       = dat_p[NUM_STAGES-1];
    assign bus.data_out_valid = vld_p[NUM_STAGES-1];
    assign count_o            = popcount(vld_p);
    assign empty_o            = (count_o == '0);
    assign full_o             = (count_o == CNT_W'(NUM_STAGES));
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
// Directed and scoreboarded checks of pipeline_elastic for NUM_STAGES 0, 2, 3 and 4.
module tb_pipeline_elastic;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n;
  logic flush0, flush2, flush3, flush4;
  logic [0:0] cnt0;
  logic [1:0] cnt2, cnt3;
  logic [2:0] cnt4;
  logic e0, f0, e2, f2, e3, f3, e4, f4;

  pipeline_elastic_if #(.WIDTH(8))  if0 ();
  pipeline_elastic_if #(.WIDTH(33)) if2 ();
  pipeline_elastic_if #(.WIDTH(8))  if3 ();
  pipeline_elastic_if #(.WIDTH(8))  if4 ();

  pipeline_elastic #(.WIDTH(8), .NUM_STAGES(0)) u0 (
    .clk_i(clk), .arst_n(arst_n), .flush_i(flush0), .bus(if0),
    .count_o(cnt0), .empty_o(e0), .full_o(f0));
  pipeline_elastic #(.WIDTH(33), .NUM_STAGES(2)) u2 (
    .clk_i(clk), .arst_n(arst_n), .flush_i(flush2), .bus(if2),
    .count_o(cnt2), .empty_o(e2), .full_o(f2));
  pipeline_elastic #(.WIDTH(8), .NUM_STAGES(3)) u3 (
    .clk_i(clk), .arst_n(arst_n), .flush_i(flush3), .bus(if3),
    .count_o(cnt3), .empty_o(e3), .full_o(f3));
  pipeline_elastic #(.WIDTH(8), .NUM_STAGES(4)) u4 (
    .clk_i(clk), .arst_n(arst_n), .flush_i(flush4), .bus(if4),
    .count_o(cnt4), .empty_o(e4), .full_o(f4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] q[$];
    logic [32:0] prev_d, exp_d;
    logic [63:0] r;
    logic        prev_stall, hold, in_x, out_x;
    int          exp_cnt, sent, got, cyc;

    arst_n = 1'b0;
    {flush0, flush2, flush3, flush4} = '0;
    if0.data_in = '0; if0.data_in_valid = 0; if0.data_out_ready = 0;
    if2.data_in = '0; if2.data_in_valid = 0; if2.data_out_ready = 0;
    if3.data_in = '0; if3.data_in_valid = 0; if3.data_out_ready = 0;
    if4.data_in = '0; if4.data_in_valid = 0; if4.data_out_ready = 0;
    #1;
    check("rst_ov",  if3.data_out_valid, 0);
    check("rst_od",  if3.data_out, 0);
    check("rst_cnt", cnt3, 0);
    check("rst_emp", e3, 1);
    check("rst_full", f3, 0);
    check("rst_rdy", if3.data_in_ready, 1);
    tick();
    tick();
    arst_n = 1'b1;

    // back-to-back stream through three stages
    if3.data_out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      if3.data_in_valid = (c < 16);
      if3.data_in       = 8'(c + 1);
      #1;
      check("t1_rdy", if3.data_in_ready, 1);
      if (c >= 3 && c <= 18) begin
        check("t1_ov", if3.data_out_valid, 1);
        check("t1_od", if3.data_out, 64'(c - 2));
      end else begin
        check("t1_ov_idle", if3.data_out_valid, 0);
      end
      if (c <= 16) check("t1_cnt", cnt3, 64'((c < 3) ? c : 3));
      tick();
    end

    // stalled output: bubbles collapse until full
    if3.data_out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if3.data_in_valid = 1;
      if3.data_in       = 8'(8'hA0 + k);
      #1;
      check("t2_acc_rdy", if3.data_in_ready, 1);
      tick();
    end
    if3.data_in = 8'hA3;
    #1;
    check("t2_full_rdy", if3.data_in_ready, 0);
    check("t2_full", f3, 1);
    check("t2_cnt", cnt3, 3);
    check("t2_ov", if3.data_out_valid, 1);
    check("t2_od", if3.data_out, 8'hA0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_hold_rdy", if3.data_in_ready, 0);
      check("t2_hold_od", if3.data_out, 8'hA0);
      check("t2_hold_ov", if3.data_out_valid, 1);
    end
    if3.data_out_ready = 1;
    #1;
    check("t2_release_rdy", if3.data_in_ready, 1);
    check("t2_release_od", if3.data_out, 8'hA0);
    for (int k = 1; k < 4; k++) begin
      tick();
      if3.data_in_valid = 0;
      #1;
      check("t2_drain_ov", if3.data_out_valid, 1);
      check("t2_drain_od", if3.data_out, 64'(8'hA0 + k));
    end
    tick();
    check("t2_end_ov", if3.data_out_valid, 0);
    check("t2_end_emp", e3, 1);

    // four stages full, simultaneous in/out transfer
    if4.data_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if4.data_in_valid = 1;
      if4.data_in       = 8'(8'hB0 + k);
      #1;
      check("t3_fill_rdy", if4.data_in_ready, 1);
      tick();
    end
    if4.data_in_valid = 0;
    #1;
    check("t3_full", f4, 1);
    check("t3_cnt", cnt4, 4);
    check("t3_full_rdy", if4.data_in_ready, 0);
    if4.data_out_ready = 1;
    if4.data_in_valid  = 1;
    if4.data_in        = 8'hB4;
    #1;
    check("t3_same_rdy", if4.data_in_ready, 1);
    check("t3_same_od", if4.data_out, 8'hB0);
    tick();
    if4.data_in_valid = 0;
    #1;
    check("t3_after_cnt", cnt4, 4);
    check("t3_after_full", f4, 1);
    check("t3_after_od", if4.data_out, 8'hB1);
    tick();
    check("t3_drain1_od", if4.data_out, 8'hB2);
    check("t3_drain1_cnt", cnt4, 3);
    tick();
    check("t3_drain2_od", if4.data_out, 8'hB3);
    check("t3_drain2_cnt", cnt4, 2);
    if4.data_out_ready = 0;

    // flush with two beats held and an input offered
    tick();
    flush4 = 1;
    if4.data_in_valid = 1;
    if4.data_in = 8'hC0;
    #1;
    check("t4_flush_rdy", if4.data_in_ready, 0);
    check("t4_flush_ov", if4.data_out_valid, 1);
    check("t4_flush_cnt", cnt4, 2);
    tick();
    flush4 = 0;
    if4.data_out_ready = 1;
    #1;
    check("t4_post_cnt", cnt4, 0);
    check("t4_post_emp", e4, 1);
    check("t4_post_ov", if4.data_out_valid, 0);
    check("t4_post_rdy", if4.data_in_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if4.data_in_valid = 0;
      #1;
      check("t4_lat_ov", if4.data_out_valid, 64'(k == 4));
      if (k == 4) check("t4_lat_od", if4.data_out, 8'hC0);
    end

    // asynchronous reset in the middle of a stream
    if3.data_out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      if3.data_in_valid = 1;
      if3.data_in = 8'(8'hD0 + k);
      tick();
    end
    if3.data_in_valid = 0;
    #1;
    check("t5_pre_cnt", cnt3, 2);
    #1;
    arst_n = 0;
    #1;
    check("t5_rst_ov", if3.data_out_valid, 0);
    check("t5_rst_od", if3.data_out, 0);
    check("t5_rst_cnt", cnt3, 0);
    check("t5_rst_emp", e3, 1);
    check("t5_rst_rdy", if3.data_in_ready, 1);
    tick();
    tick();
    arst_n = 1;
    if3.data_out_ready = 1;
    if3.data_in_valid = 1;
    if3.data_in = 8'hD5;
    #1;
    check("t5_resume_rdy", if3.data_in_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if3.data_in_valid = 0;
      #1;
      check("t5_resume_ov", if3.data_out_valid, 64'(k == 3));
      if (k == 3) check("t5_resume_od", if3.data_out, 8'hD5);
    end

    // zero-stage pass-through
    if0.data_in = 8'h5A; if0.data_in_valid = 1; if0.data_out_ready = 1;
    #1;
    check("n0_od", if0.data_out, 8'h5A);
    check("n0_ov", if0.data_out_valid, 1);
    check("n0_rdy", if0.data_in_ready, 1);
    check("n0_cnt", cnt0, 0);
    check("n0_emp", e0, 1);
    check("n0_full", f0, 1);
    flush0 = 1;
    #1;
    check("n0_flush_ov", if0.data_out_valid, 0);
    check("n0_flush_rdy", if0.data_in_ready, 0);
    flush0 = 0; if0.data_out_ready = 0;
    #1;
    check("n0_stall_rdy", if0.data_in_ready, 0);

    // random valid/ready traffic against an in-order scoreboard
    tick();
    prev_stall = 0; prev_d = '0; hold = 0;
    exp_cnt = 0; sent = 0; got = 0; cyc = 0;
    while (got < 600 && cyc < 20000) begin
      if (!hold) begin
        r = {$urandom(), $urandom()};
        if2.data_in_valid = (sent < 600) && ($urandom_range(1) == 1);
        if2.data_in = r[32:0];
      end
      if2.data_out_ready = ($urandom_range(1) == 1);
      #1;
      if (prev_stall) begin
        check("rnd_stall_ov", if2.data_out_valid, 1);
        check("rnd_stall_od", if2.data_out, prev_d);
      end
      check("rnd_cnt", cnt2, 64'(exp_cnt));
      check("rnd_emp", e2, 64'(exp_cnt == 0));
      in_x  = if2.data_in_valid & if2.data_in_ready;
      out_x = if2.data_out_valid & if2.data_out_ready;
      if (out_x) begin
        if (q.size() == 0) begin
          check("rnd_extra_beat", 1, 0);
        end else begin
          exp_d = q.pop_front();
          check("rnd_data", if2.data_out, exp_d);
          got++;
        end
      end
      if (in_x) begin
        q.push_back(if2.data_in);
        sent++;
      end
      exp_cnt = exp_cnt + int'(in_x) - int'(out_x);
      prev_stall = if2.data_out_valid & !if2.data_out_ready;
      prev_d = if2.data_out;
      hold = if2.data_in_valid & !if2.data_in_ready;
      tick();
      cyc++;
    end
    check("rnd_beats_delivered", 64'(got), 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
